// File: rtl/multi_inverter_filt_pkg.sv
// Shared defaults and sizing helper for the multi-channel filtered inverter.
package multi_inverter_filt_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILT_CYCLES = 4;

  // Counter must hold FILT_CYCLES-1 and never wrap.
  function automatic int unsigned cnt_width(input int unsigned filt_cycles);
    return (filt_cycles < 1) ? 1 : $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/multi_inverter_filt_if.sv
// Channel bundle between the lab I/O side (master) and the filter block (slave).
interface multi_inverter_filt_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] pol_mask;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] chg;

  modport master (
    output en,
    output in,
    output pol_mask,
    input  out,
    input  chg
  );

  modport slave (
    input  en,
    input  in,
    input  pol_mask,
    output out,
    output chg
  );
endinterface

// File: rtl/multi_inverter_filt_channel.sv
// One channel: input synchroniser followed by a consecutive-cycle debounce filter.
module multi_inverter_filt_channel
  import multi_inverter_filt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic f
);

  localparam int unsigned CW = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q;
  logic                   f_q;

  // Synchroniser runs regardless of en so no stale level is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      f_q   <= 1'b0;
    end else if (en) begin
      if (s == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        f_q   <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign f = f_q;

endmodule

// File: rtl/multi_inverter_filt.sv
// WIDTH filtered channels with per-channel polarity, registered outputs and change strobes.
module multi_inverter_filt
  import multi_inverter_filt_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES
) (
  input logic                  clk,
  input logic                  rst,
  multi_inverter_filt_if.slave bus
);

  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_prev_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] chg_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    multi_inverter_filt_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .en  (bus.en),
      .din (bus.in[i]),
      .f   (f[i])
    );
  end

  // f_prev_q tracks f one edge behind, so chg lines up with the out update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_prev_q <= '0;
      out_q    <= '0;
      chg_q    <= '0;
    end else begin
      f_prev_q <= f;
      out_q    <= f ^ bus.pol_mask;
      chg_q    <= f ^ f_prev_q;
    end
  end

  assign bus.out = out_q;
  assign bus.chg = chg_q;

endmodule

// File: tb/tb_multi_inverter_filt.sv
// Directed bench for multi_inverter_filt: expected out/chg are queued per edge and checked.
`timescale 1ns/100ps
module tb_multi_inverter_filt;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  o;
    logic [7:0]  c;
    string       tag;
  } exp_t;

  logic        clk = 1'b1;
  logic        rst;
  int unsigned edge_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  exp_t        q[$];

  multi_inverter_filt_if #(.WIDTH(8)) bus ();

  multi_inverter_filt #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .FILT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp_v, edge_cnt);
  endtask

  function automatic void push(input int unsigned dly, input logic [7:0] o,
                               input logic [7:0] c, input string tag);
    exp_t e;
    e.cyc = edge_cnt + dly;
    e.o   = o;
    e.c   = c;
    e.tag = tag;
    q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: compare every entry due at this edge.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == edge_cnt) begin
        check8({q[i].tag, ".out"}, bus.out, q[i].o);
        check8({q[i].tag, ".chg"}, bus.chg, q[i].c);
        q.delete(i);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.in       = 8'hFF;
    bus.pol_mask = 8'h0F;

    // Reset holds outputs at zero, not at pol_mask.
    #1;
    check8("rst_out_a", bus.out, 8'h00);
    check8("rst_chg_a", bus.chg, 8'h00);
    #14;
    check8("rst_out_b", bus.out, 8'h00);
    check8("rst_chg_b", bus.chg, 8'h00);
    #10;
    rst = 1'b0;
    push(1, 8'h0F, 8'h00, "rst_first");
    push(6, 8'h0F, 8'h00, "rst_pre");
    push(7, 8'hF0, 8'hFF, "rst_rise");
    push(8, 8'hF0, 8'h00, "rst_end");
    tick(10);

    // Return to all-low, pass-through polarity.
    bus.in       = 8'h00;
    bus.pol_mask = 8'h00;
    push(1, 8'hFF, 8'h00, "clr_hold");
    push(7, 8'h00, 8'hFF, "clr_fall");
    push(8, 8'h00, 8'h00, "clr_end");
    tick(10);

    // Latency: input change before edge k shows at edge k+6.
    bus.in = 8'h01;
    push(6, 8'h00, 8'h00, "lat_early");
    push(7, 8'h01, 8'h01, "lat_hit");
    push(8, 8'h01, 8'h00, "lat_end");
    tick(10);

    // 3-cycle glitch on bit 3 is rejected.
    for (int d = 1; d <= 12; d++) push(d, 8'h01, 8'h00, "glitch3");
    bus.in = 8'h09;
    tick(3);
    bus.in = 8'h01;
    tick(12);

    // 4-cycle pulse on bit 3 passes, rise and fall each strobe.
    push(6,  8'h01, 8'h00, "g4_pre");
    push(7,  8'h09, 8'h08, "g4_rise");
    push(8,  8'h09, 8'h00, "g4_rise_end");
    push(10, 8'h09, 8'h00, "g4_hold");
    push(11, 8'h01, 8'h08, "g4_fall");
    push(12, 8'h01, 8'h00, "g4_fall_end");
    bus.in = 8'h09;
    tick(4);
    bus.in = 8'h01;
    tick(12);

    // Polarity-only change: out flips next edge, no strobe.
    bus.in = 8'hA5;
    push(7, 8'hA5, 8'hA4, "pol_settle");
    tick(10);
    bus.pol_mask = 8'hFF;
    push(0, 8'hA5, 8'h00, "pol_before");
    push(1, 8'h5A, 8'h00, "pol_flip");
    push(2, 8'h5A, 8'h00, "pol_hold");
    tick(4);

    // Enable freeze after two qualifying cycles on bit 1.
    bus.pol_mask = 8'h00;
    bus.in       = 8'hA7;
    push(1,  8'hA5, 8'h00, "en_polback");
    push(7,  8'hA5, 8'h00, "en_no_early");
    push(9,  8'hA5, 8'h00, "en_frozen");
    push(11, 8'hA5, 8'h00, "en_pre");
    push(12, 8'hA7, 8'h02, "en_rise");
    push(13, 8'hA7, 8'h00, "en_end");
    tick(4);
    bus.en = 1'b0;
    tick(5);
    bus.en = 1'b1;
    tick(8);

    // Prepare for mid-count reset: all-low inputs, nonzero polarity.
    bus.pol_mask = 8'hF0;
    bus.in       = 8'h00;
    push(1, 8'h57, 8'h00, "pre6_pol");
    push(7, 8'hF0, 8'hA7, "pre6_fall");
    push(8, 8'hF0, 8'h00, "pre6_end");
    tick(10);

    // Async reset between edges while bit 2 is qualifying.
    bus.in = 8'h04;
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    check8("arst_out", bus.out, 8'h00);
    check8("arst_chg", bus.chg, 8'h00);
    #2;
    rst = 1'b0;
    push(1, 8'hF0, 8'h00, "rr_first");
    push(6, 8'hF0, 8'h00, "rr_pre");
    push(7, 8'hF4, 8'h04, "rr_rise");
    push(8, 8'hF4, 8'h00, "rr_end");
    tick(10);

    for (int k = 0; k < 50; k++) begin
      if (q.size() == 0) break;
      tick(1);
    end
    n_checks++;
    assert (q.size() == 0) n_pass++;
    else $error("FAIL drain: observed %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
